// File: rtl/tdm_demux4.sv
// Four-channel TDM receiver: tracks slot position from a frame-sync marker
// with a flywheel HUNT/LOCKED state machine and reassembles each frame into four registered outputs.
module tdm_demux4 #(
  parameter int WIDTH      = 4,
  parameter int MISS_LIMIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam int MW = (MISS_LIMIT < 1) ? 1 : $clog2(MISS_LIMIT + 1);
  localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic [MW-1:0]    miss_inc;
  logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [WIDTH-1:0] y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
  logic             fv_q, fv_d;
  logic             se_q, se_d;

  assign miss_inc = miss_q + MW'(1);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    miss_d  = miss_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    y3_d    = y3_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;

    if (din_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (frame_sync) begin
            s0_d    = din;
            slot_d  = 2'd1;
            miss_d  = '0;
            state_d = ST_LOCKED;
          end
        end

        ST_LOCKED: begin
          if (slot_q == 2'd0) begin
            if (frame_sync) begin
              s0_d   = din;
              slot_d = 2'd1;
              miss_d = '0;
            end else if (miss_inc == MISS_MAX) begin
              // Too many consecutive missing markers: drop the beat and re-hunt.
              state_d = ST_HUNT;
              se_d    = 1'b1;
              slot_d  = 2'd0;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
              s0_d   = din;
              slot_d = 2'd1;
            end
          end else if (frame_sync) begin
            // Marker mid-frame: abandon the partial frame and realign here.
            se_d   = 1'b1;
            s0_d   = din;
            slot_d = 2'd1;
            miss_d = '0;
          end else begin
            slot_d = slot_q + 2'd1;
            case (slot_q)
              2'd1: s1_d = din;
              2'd2: s2_d = din;
              2'd3: begin
                y0_d = s0_q;
                y1_d = s1_q;
                y2_d = s2_q;
                y3_d = din;
                fv_d = 1'b1;
              end
              default: ;
            endcase
          end
        end

        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HUNT;
      slot_q  <= 2'd0;
      miss_q  <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      y3_q    <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      miss_q  <= miss_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      y3_q    <= y3_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
    end
  end

  assign y0          = y0_q;
  assign y1          = y1_q;
  assign y2          = y2_q;
  assign y3          = y3_q;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign locked      = (state_q == ST_LOCKED);

endmodule
